// File: rtl/runs_test.sv
// runs_test: NIST-style runs test over 2^LOG2_N-bit sequences with a frequency prerequisite,
// using a sequential shift-add multiplier for S*(n-S).
module runs_test #(
    parameter int LOG2_N   = 7,
    parameter int FREQ_TOL = 22,
    parameter int RUNS_TOL = 17
) (
    input  logic clk,
    input  logic rst_n,
    input  logic epsilon_rsc_dat,
    input  logic epsilon_vld,
    output logic epsilon_rdy,
    output logic is_random_rsc_dat,
    output logic valid_rsc_dat,
    output logic freq_pass_rsc_dat,
    output logic runs_pass_rsc_dat
);
    localparam int C  = LOG2_N + 1;
    localparam int W  = 2 * LOG2_N + 2;
    localparam int TW = W + 34;
    localparam logic [C-1:0] N = {1'b1, {LOG2_N{1'b0}}};

    typedef enum logic [1:0] {COLLECT, MULT, DECIDE} state_t;

    state_t state_q, state_d;
    logic [C-1:0] cnt_q, cnt_d, s_q, s_d, v_q, v_d, b_q, b_d, step_q, step_d;
    logic [W-1:0] a_q, a_d, p_q, p_d;
    logic prev_q, prev_d, freq_q, freq_d, runs_q, runs_d, rand_q, rand_d, valid_q, valid_d;
    logic [C-1:0] s_n, v_n;
    logic [TW-1:0] two_s, n_w, fdiff, vn, p2, rdiff;
    logic fpass, rpass;

    assign s_n = s_q + C'(epsilon_rsc_dat);
    assign v_n = (cnt_q == '0 || epsilon_rsc_dat != prev_q) ? v_q + C'(1) : v_q;

    // Tolerance compares are done wide so large RUNS_TOL*n never wraps.
    assign two_s = TW'(s_q) << 1;
    assign n_w   = TW'(N);
    assign fdiff = two_s >= n_w ? two_s - n_w : n_w - two_s;
    assign fpass = fdiff <= TW'(FREQ_TOL);
    assign vn    = TW'(v_q) << LOG2_N;
    assign p2    = TW'(p_q) << 1;
    assign rdiff = vn >= p2 ? vn - p2 : p2 - vn;
    assign rpass = fpass && rdiff <= (TW'(RUNS_TOL) << LOG2_N);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        v_d     = v_q;
        prev_d  = prev_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        step_d  = step_q;
        freq_d  = freq_q;
        runs_d  = runs_q;
        rand_d  = rand_q;
        valid_d = 1'b0;
        if (state_q == COLLECT) begin
            if (epsilon_vld) begin
                cnt_d  = cnt_q + C'(1);
                s_d    = s_n;
                v_d    = v_n;
                prev_d = epsilon_rsc_dat;
                if (cnt_q == N - C'(1)) begin
                    state_d = MULT;
                    a_d     = W'(s_n);
                    b_d     = N - s_n;
                    p_d     = '0;
                    step_d  = '0;
                end
            end
        end else if (state_q == MULT) begin
            p_d    = b_q[0] ? p_q + a_q : p_q;
            a_d    = a_q << 1;
            b_d    = b_q >> 1;
            step_d = step_q + C'(1);
            state_d = step_q == C'(LOG2_N) ? DECIDE : MULT;
        end else begin
            freq_d  = fpass;
            runs_d  = rpass;
            rand_d  = fpass && rpass;
            valid_d = 1'b1;
            cnt_d   = '0;
            s_d     = '0;
            v_d     = '0;
            state_d = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            s_q     <= '0;
            v_q     <= '0;
            prev_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            step_q  <= '0;
            freq_q  <= 1'b0;
            runs_q  <= 1'b0;
            rand_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            v_q     <= v_d;
            prev_q  <= prev_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            step_q  <= step_d;
            freq_q  <= freq_d;
            runs_q  <= runs_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
        end
    end

    assign epsilon_rdy       = state_q == COLLECT;
    assign is_random_rsc_dat = rand_q;
    assign valid_rsc_dat     = valid_q;
    assign freq_pass_rsc_dat = freq_q;
    assign runs_pass_rsc_dat = runs_q;
endmodule

// File: tb/tb_runs_test.sv
// tb_runs_test: scoreboard bench for runs_test with a sequence-level reference model.
module tb_runs_test;
    localparam int L = 3, N = 8, FT = 2, RT = 2;

    logic clk = 0, rst_n = 0, dat = 0, vld = 0;
    logic rdy, rnd, valid, fp, rp;

    runs_test #(.LOG2_N(L), .FREQ_TOL(FT), .RUNS_TOL(RT)) dut (
        .clk(clk), .rst_n(rst_n), .epsilon_rsc_dat(dat), .epsilon_vld(vld),
        .epsilon_rdy(rdy), .is_random_rsc_dat(rnd), .valid_rsc_dat(valid),
        .freq_pass_rsc_dat(fp), .runs_pass_rsc_dat(rp)
    );

    always #5 clk = ~clk;

    typedef struct {bit f; bit r; bit z; int edge_n;} exp_t;
    exp_t exp_q[$];
    bit bits_q[$];
    int cyc = 0, total = 0, bad = 0, last_acc = -100;
    bit in_reset = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at edge %0d", name, act, req, cyc);
        end
    endtask

    function automatic int iabs(int x);
        return x < 0 ? -x : x;
    endfunction

    // Verdict computed straight from the accepted bit list.
    task automatic model_push(int e);
        int s = 0, v = 0, p;
        exp_t x;
        foreach (bits_q[i]) begin
            s += int'(bits_q[i]);
            if (i == 0 || bits_q[i] != bits_q[i-1]) v++;
        end
        p = s * (N - s);
        x.f = iabs(2 * s - N) <= FT;
        x.r = x.f && iabs(v * N - 2 * p) <= RT * N;
        x.z = x.f && x.r;
        x.edge_n = e;
        exp_q.push_back(x);
        bits_q.delete();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!in_reset) begin
            chk("rdy", int'(rdy), int'(!(cyc >= last_acc && cyc < last_acc + 5)));
            if (valid) begin
                if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("freq", int'(fp), int'(e.f));
                    chk("runs", int'(rp), int'(e.r));
                    chk("is_random", int'(rnd), int'(e.z));
                    chk("latency", cyc - e.edge_n, 5);
                end
            end
        end
    end

    task automatic send(logic [7:0] seq, bit tog, int nb);
        for (int i = 0; i < nb; i++) begin
            int tries = 0;
            bit done = 0;
            while (!done) begin
                @(negedge clk);
                vld = tog ? 1'($urandom_range(0, 1)) : 1'b1;
                dat = seq[7-i];
                #1;
                if (vld && rdy) begin
                    done = 1;
                    bits_q.push_back(dat);
                    if (bits_q.size() == N) begin
                        model_push(cyc + 1);
                        last_acc = cyc + 1;
                    end
                end else if (++tries > 60) begin
                    chk("send_timeout", 0, 1);
                    return;
                end
            end
        end
    endtask

    task automatic idle(int k);
        repeat (k) begin
            @(negedge clk);
            vld = 0;
        end
    endtask

    task automatic do_reset(int hold);
        #2;
        in_reset = 1;
        rst_n = 0;
        vld = 0;
        #1;
        chk("rst_rdy", int'(rdy), 1);
        chk("rst_valid", int'(valid), 0);
        chk("rst_rand", int'(rnd), 0);
        chk("rst_freq", int'(fp), 0);
        chk("rst_runs", int'(rp), 0);
        exp_q.delete();
        bits_q.delete();
        last_acc = -100;
        repeat (hold) @(negedge clk);
        #2;
        rst_n = 1;
        in_reset = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(2);
        send(8'b11101000, 0, 8);
        send(8'b10101010, 0, 8);
        send(8'b11111111, 0, 8);
        send(8'b11001010, 0, 8);
        idle(8);
        send(8'b11101000, 1, 8);
        idle(8);
        send(8'b00000000, 0, 8);
        idle(8);
        send(8'b11101000, 0, 5);
        idle(1);
        do_reset(2);
        send(8'b11101000, 0, 8);
        idle(2);
        do_reset(2);
        send(8'b11101000, 0, 8);
        idle(8);
        repeat (40) begin
            send(8'($urandom), 1'($urandom_range(0, 1)), 8);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 6));
        end
        idle(1);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
